search_display: RTL and testbench

Display-side consumer of the search-mode flags. It takes the one-hot query flags (`search_use`, `search_on`, `search_reminder`) plus the values they select, converts the selected value to BCD with a sequential double-dabble engine, and drives an 8-digit multiplexed seven-segment display. It sits between the search-mode block and the board display pins.

---
 rtl/search_display_if.sv | 28 ++
 rtl/search_display.sv | 228 ++++++++++++++++++++++
 tb/tb_search_display.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/search_display_if.sv
// Query bus between the search-mode block and the display driver:
// power/mode flags and the values they select, plus the display pins and busy.
interface search_display_if;
  logic       power_status;
  logic       search_use;
  logic       search_on;
  logic       search_reminder;
  logic [6:0] use_hh;
  logic [6:0] use_mm;
  logic [6:0] use_ss;
  logic [6:0] on_time;
  logic [6:0] remind_hh;
  logic [7:0] seg_en;
  logic [7:0] seg_out;
  logic       busy;

  modport master (
    output power_status, search_use, search_on, search_reminder,
    output use_hh, use_mm, use_ss, on_time, remind_hh,
    input  seg_en, seg_out, busy
  );

  modport slave (
    input  power_status, search_use, search_on, search_reminder,
    input  use_hh, use_mm, use_ss, on_time, remind_hh,
    output seg_en, seg_out, busy
  );
endinterface

// File: rtl/search_display.sv
// Converts the value selected by the search flags to BCD (sequential double-dabble)
// and drives an 8-digit multiplexed seven-segment display.
module search_display #(
  parameter int SCAN_DIV    = 100_000,
  parameter int REFRESH_DIV = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  search_display_if.slave bus
);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {M_NONE, M_USE, M_ON, M_REM} mode_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_NEXT, S_COMMIT} state_t;

  mode_t              mode, mode_q, mode_l, disp_mode;
  state_t             state;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [REF_W-1:0]   ref_cnt;
  logic [2:0]         dig_idx;
  logic [2:0]         bit_cnt;
  logic [1:0]         fidx;
  logic [6:0]         fld [3];
  logic [6:0]         cur_fld;
  logic               cur_bit;
  logic [7:0]         bcd;
  logic [7:0]         dig [3];
  logic [7:0]         disp [3];
  logic               busy_r;
  logic               tick;
  logic [7:0]         seg_en_c, seg_out_c;

  function automatic logic [6:0] clamp99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  // One double-dabble iteration: add 3 to nibbles >= 5, then shift in the next bit.
  function automatic logic [7:0] dd_step(input logic [7:0] b, input logic in_bit);
    logic [7:0] a;
    a[7:4] = (b[7:4] >= 4'd5) ? b[7:4] + 4'd3 : b[7:4];
    a[3:0] = (b[3:0] >= 4'd5) ? b[3:0] + 4'd3 : b[3:0];
    return {a[6:0], in_bit};
  endfunction

  function automatic logic [7:0] seg_num(input logic [3:0] n);
    case (n)
      4'd0:    return 8'b1111_1100;
      4'd1:    return 8'b0110_0000;
      4'd2:    return 8'b1101_1010;
      4'd3:    return 8'b1111_0010;
      4'd4:    return 8'b0110_0110;
      4'd5:    return 8'b1011_0110;
      4'd6:    return 8'b1011_1110;
      4'd7:    return 8'b1110_0000;
      4'd8:    return 8'b1111_1110;
      4'd9:    return 8'b1111_0110;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] seg_letter(input mode_t m);
    case (m)
      M_USE:   return 8'b0111_1100;
      M_ON:    return 8'b0011_1010;
      M_REM:   return 8'b0000_1010;
      default: return 8'b0000_0000;
    endcase
  endfunction

  always_comb begin
    mode = M_NONE;
    if (bus.power_status) begin
      if (bus.search_reminder)  mode = M_REM;
      else if (bus.search_on)   mode = M_ON;
      else if (bus.search_use)  mode = M_USE;
    end
  end

  assign tick = (ref_cnt == REF_LAST);

  // Scanner and refresh timebase free-run regardless of mode or blanking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      dig_idx  <= 3'd7;
      ref_cnt  <= '0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + 1'b1;
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx - 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // Converter control: NONE beats restart, restart beats normal sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy_r    <= 1'b0;
      mode_q    <= M_NONE;
      mode_l    <= M_NONE;
      disp_mode <= M_NONE;
      bit_cnt   <= '0;
      fidx      <= '0;
      for (int i = 0; i < 3; i++) disp[i] <= '0;
    end else begin
      mode_q <= mode;
      if (mode == M_NONE) begin
        state     <= S_IDLE;
        busy_r    <= 1'b0;
        disp_mode <= M_NONE;
        for (int i = 0; i < 3; i++) disp[i] <= '0;
      end else if (mode != mode_q) begin
        state  <= S_LOAD;
        busy_r <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (tick) begin
            state  <= S_LOAD;
            busy_r <= 1'b1;
          end
          S_LOAD: begin
            mode_l  <= mode;
            bit_cnt <= '0;
            fidx    <= '0;
            state   <= S_SHIFT;
          end
          S_SHIFT: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd5) state <= S_NEXT;
          end
          // NEXT performs the seventh shift while storing the field's digits.
          S_NEXT: begin
            bit_cnt <= '0;
            if (fidx < 2'd2) begin
              fidx  <= fidx + 2'd1;
              state <= S_SHIFT;
            end else begin
              state <= S_COMMIT;
            end
          end
          S_COMMIT: begin
            disp_mode <= mode_l;
            for (int i = 0; i < 3; i++) disp[i] <= dig[i];
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
          default: begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    cur_fld = fld[0];
    case (fidx)
      2'd1:    cur_fld = fld[1];
      2'd2:    cur_fld = fld[2];
      default: cur_fld = fld[0];
    endcase
  end

  assign cur_bit = cur_fld[3'd6 - bit_cnt];

  // Conversion datapath; restarts always pass through LOAD, which reinitialises it.
  always_ff @(posedge clk) begin
    case (state)
      S_LOAD: begin
        bcd <= '0;
        case (mode)
          M_USE: begin
            fld[2] <= clamp99(bus.use_hh);
            fld[1] <= clamp99(bus.use_mm);
            fld[0] <= clamp99(bus.use_ss);
          end
          M_ON: begin
            fld[2] <= '0;
            fld[1] <= '0;
            fld[0] <= clamp99(bus.on_time);
          end
          default: begin
            fld[2] <= '0;
            fld[1] <= '0;
            fld[0] <= clamp99(bus.remind_hh);
          end
        endcase
      end
      S_SHIFT: bcd <= dd_step(bcd, cur_bit);
      S_NEXT: begin
        for (int i = 0; i < 3; i++)
          if (fidx == 2'(i)) dig[i] <= dd_step(bcd, cur_bit);
        bcd <= '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    seg_en_c  = '0;
    seg_out_c = '0;
    if (disp_mode != M_NONE) begin
      seg_en_c = 8'b1 << dig_idx;
      case (dig_idx)
        3'd7: seg_out_c = seg_letter(disp_mode);
        3'd5: if (disp_mode == M_USE) seg_out_c = seg_num(disp[2][7:4]);
        3'd4: if (disp_mode == M_USE) seg_out_c = seg_num(disp[2][3:0]) | 8'h01;
        3'd3: if (disp_mode == M_USE) seg_out_c = seg_num(disp[1][7:4]);
        3'd2: if (disp_mode == M_USE) seg_out_c = seg_num(disp[1][3:0]) | 8'h01;
        3'd1: seg_out_c = seg_num(disp[0][7:4]);
        3'd0: seg_out_c = seg_num(disp[0][3:0]);
        default: seg_out_c = '0;
      endcase
    end
  end

  assign bus.seg_en  = seg_en_c;
  assign bus.seg_out = seg_out_c;
  assign bus.busy    = busy_r;
endmodule

// File: tb/tb_search_display.sv
// Directed/randomised bench for search_display with a digit-level reference model.
module tb_search_display;
  localparam int SCAN_DIV    = 4;
  localparam int REFRESH_DIV = 64;
  localparam int USE = 1, ON = 2, REM = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  search_display_if bus();

  search_display #(.SCAN_DIV(SCAN_DIV), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int m_hh, m_mm, m_ss, m_on, m_rem;

  // Cycles since reset release; the refresh tick lands where cyc % REFRESH_DIV == REFRESH_DIV-1.
  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] num_seg(input int n);
    case (n)
      0: return 8'b1111_1100;  1: return 8'b0110_0000;
      2: return 8'b1101_1010;  3: return 8'b1111_0010;
      4: return 8'b0110_0110;  5: return 8'b1011_0110;
      6: return 8'b1011_1110;  7: return 8'b1110_0000;
      8: return 8'b1111_1110;  9: return 8'b1111_0110;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic int clip(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  // Expected segment pattern of digit d, built from the mode rules and the raw inputs.
  function automatic logic [7:0] exp_seg(input int m, input int d);
    int f2, f1, f0;
    logic [7:0] dp;
    f2 = (m == USE) ? clip(m_hh) : 0;
    f1 = (m == USE) ? clip(m_mm) : 0;
    f0 = (m == USE) ? clip(m_ss) : (m == ON) ? clip(m_on) : clip(m_rem);
    dp = (m == USE) ? 8'h01 : 8'h00;
    case (d)
      7: return (m == USE) ? 8'b0111_1100 : (m == ON) ? 8'b0011_1010 : 8'b0000_1010;
      6: return 8'h00;
      5: return (m == USE) ? num_seg(f2 / 10) : 8'h00;
      4: return (m == USE) ? (num_seg(f2 % 10) | dp) : 8'h00;
      3: return (m == USE) ? num_seg(f1 / 10) : 8'h00;
      2: return (m == USE) ? (num_seg(f1 % 10) | dp) : 8'h00;
      1: return num_seg(f0 / 10);
      default: return num_seg(f0 % 10);
    endcase
  endfunction

  task automatic set_vals(input int hh, input int mm, input int ss, input int ot, input int rh);
    m_hh = hh; m_mm = mm; m_ss = ss; m_on = ot; m_rem = rh;
    bus.use_hh = 7'(hh); bus.use_mm = 7'(mm); bus.use_ss = 7'(ss);
    bus.on_time = 7'(ot); bus.remind_hh = 7'(rh);
  endtask

  task automatic set_flags(input logic u, input logic o, input logic r);
    bus.search_use = u; bus.search_on = o; bus.search_reminder = r;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  task automatic check_display(input string tag, input int m);
    logic [7:0] got [8];
    int bad, order_bad, prev;
    bad = 0; order_bad = 0; prev = -1;
    for (int i = 0; i < 8; i++) got[i] = 'x;
    for (int k = 0; k < 8 * SCAN_DIV; k++) begin
      @(negedge clk);
      if ($onehot(bus.seg_en)) begin
        for (int i = 0; i < 8; i++)
          if (bus.seg_en[i]) begin
            got[i] = bus.seg_out;
            if (prev >= 0 && i != prev && i != ((prev + 7) % 8)) order_bad++;
            prev = i;
          end
      end else begin
        bad++;
      end
    end
    check({tag, "_onehot"}, bad, 0);
    check({tag, "_order"}, order_bad, 0);
    for (int d = 7; d >= 0; d--)
      check($sformatf("%s_dig%0d", tag, d), got[d], exp_seg(m, d));
  endtask

  task automatic go_none();
    set_flags(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n, early, t_tick, m;
    bus.power_status = 1'b1;
    set_flags(1'b0, 1'b0, 1'b0);
    set_vals(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_seg_en", bus.seg_en, 8'h00);
    check("rst_seg_out", bus.seg_out, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_blank", bus.seg_en, 8'h00);

    // Use mode 12:05:59
    set_vals(12, 5, 59, 0, 0);
    set_flags(1'b1, 1'b0, 1'b0);
    count_busy(n);
    check("use_busy_len", n, 23);
    check_display("use", USE);

    // Reset asserted while a conversion is running
    set_flags(1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b0;
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_rst_seg_en", bus.seg_en, 8'h00);
    check("mid_rst_seg_out", bus.seg_out, 8'h00);
    check("mid_rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    early = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.seg_en != 8'h00 || bus.busy) early++;
    end
    check("post_rst_dark", early, 0);

    // On mode, on_time = 7
    set_vals(0, 0, 0, 7, 0);
    set_flags(1'b0, 1'b1, 1'b0);
    count_busy(n);
    check("on_busy_len", n, 23);
    check_display("on", ON);

    // Reminder raised 5 cycles into a use conversion; 120 clamps to 99
    go_none();
    set_vals($urandom_range(0, 99), $urandom_range(0, 99), $urandom_range(0, 99), 0, 120);
    set_flags(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    set_flags(1'b1, 1'b0, 1'b1);
    count_busy(n);
    check("restart_busy_len", n, 23);
    check_display("rem", REM);

    // Power lost mid-conversion, then restored
    set_flags(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("pwr_busy_before", bus.busy, 1'b1);
    bus.power_status = 1'b0;
    @(negedge clk);
    check("pwr_seg_en", bus.seg_en, 8'h00);
    check("pwr_busy", bus.busy, 1'b0);
    repeat (4) @(negedge clk);
    bus.power_status = 1'b1;
    count_busy(n);
    check("pwr_up_busy_len", n, 23);
    check_display("pwr_use", USE);

    // All flags raised together resolve to reminder
    go_none();
    set_flags(1'b1, 1'b1, 1'b1);
    count_busy(n);
    check("all_busy_len", n, 23);
    check_display("all", REM);

    // Randomised values, mode and lower-priority flags
    for (int it = 0; it < 4; it++) begin
      go_none();
      set_vals($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127),
               $urandom_range(0, 127), $urandom_range(0, 127));
      m = $urandom_range(1, 3);
      set_flags((m == USE) ? 1'b1 : 1'($urandom_range(0, 1)),
                (m == ON) ? 1'b1 : (m == REM) ? 1'($urandom_range(0, 1)) : 1'b0,
                (m == REM) ? 1'b1 : 1'b0);
      count_busy(n);
      check($sformatf("rnd%0d_busy_len", it), n, 23);
      check_display($sformatf("rnd%0d", it), m);
    end

    // Value change only reaches the display through a refresh tick
    go_none();
    set_vals(1, 2, 30, 0, 0);
    set_flags(1'b1, 1'b0, 1'b0);
    count_busy(n);
    check("ref_busy_len", n, 23);
    check_display("ref_old", USE);
    set_vals(1, 2, 31, 0, 0);
    t_tick = cyc + (REFRESH_DIV - 1 - (cyc % REFRESH_DIV));
    early = 0;
    for (int k = 0; k < 88; k++) begin
      @(negedge clk);
      if (bus.seg_en == 8'h01 && cyc < t_tick && bus.seg_out !== num_seg(0)) early++;
    end
    check("ref_no_early_update", early, 0);
    check_display("ref_new", USE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
